// File: rtl/cob_rom_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// cob_rom_fetch_arbiter
//
// Purpose
//   Shares the single-port co_B coefficient ROM between two burst requesters.
//   Each requester asks for a run of consecutive coefficients (base, length).
//   One request is granted at a time; the granted burst is read out at one ROM
//   read per cycle and the returning data is tagged with the owner id and a
//   last-beat marker.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req0_val/rdy/base/len   requester 0 burst request (valid/ready)
//   req1_val/rdy/base/len   requester 1 burst request (valid/ready)
//   rom_ena, rom_addr       ROM read strobe and address (one read per cycle)
//   rom_dout                ROM read data, ROM_LAT cycles after rom_ena
//   para_val/out/id/last    tagged coefficient stream (no backpressure)
//   busy                    burst issuing or reads still in flight
//   dbg_state               FSM state for observation (0 = IDLE, 1 = BURST)
//
// Handshake: a request transfers in the cycle where reqN_val & reqN_rdy are
//   both high. reqN_rdy does not depend on reqN_base/len, only on the valids,
//   the FSM state and the arbitration pointer. At most one rdy is high.
//   para_val has no ready; the consumer must take every beat.
//
// Configuration
//   COB_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie and the
//                          round-robin pointer does not exist.
//                          undefined (default): round-robin arbitration.
// ---------------------------------------------------------------------------
module cob_rom_fetch_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 11,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_val,
  output logic              req0_rdy,
  input  logic [ADDR_W-1:0] req0_base,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req1_val,
  output logic              req1_rdy,
  input  logic [ADDR_W-1:0] req1_base,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              para_val,
  output logic [DATA_W-1:0] para_out,
  output logic              para_id,
  output logic              para_last,
  output logic              busy,
  output logic              dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;     // address of the next read
  logic [LEN_W-1:0]    rem_q, rem_d;     // reads left after the current one
  logic                id_q, id_d;       // owner of the active burst

  // Read-tracking shift register; bit 0 is the newest read, bit ROM_LAT-1
  // lines up with rom_dout.
  logic [ROM_LAT-1:0]  pv_q, pv_d;
  logic [ROM_LAT-1:0]  pi_q, pi_d;
  logic [ROM_LAT-1:0]  pl_q, pl_d;
  logic [ROM_LAT:0]    pv_ext, pi_ext, pl_ext;

`ifndef COB_ARB_FIXED_PRIO_EN
  logic                rr_q, rr_d;       // requester favoured on a tie
`endif

  logic                grant0, grant1;
  logic                idle_ok;
  logic                accept;
  logic                acc_id;
  logic [ADDR_W-1:0]   acc_base;
  logic [LEN_W-1:0]    acc_len;
  logic                issue;
  logic                issue_last;

  // -------------------------------------------------------------------------
  // Arbitration: a lone valid requester always wins; a tie is settled by the
  // pointer (or by fixed priority when configured).
  // -------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef COB_ARB_FIXED_PRIO_EN
    grant0 = req0_val;
    grant1 = req1_val & ~req0_val;
`else
    if (req0_val && req1_val) begin
      grant0 = ~rr_q;
      grant1 = rr_q;
    end else begin
      grant0 = req0_val;
      grant1 = req1_val;
    end
`endif
  end

  // rdy is held low while reset is asserted so nothing is accepted then.
  assign idle_ok  = (state_q == S_IDLE) & rst_n;
  assign req0_rdy = idle_ok & grant0;
  assign req1_rdy = idle_ok & grant1;

  assign accept   = req0_rdy | req1_rdy;
  assign acc_id   = req1_rdy;
  assign acc_base = req1_rdy ? req1_base : req0_base;
  assign acc_len  = req1_rdy ? req1_len  : req0_len;

  assign issue      = (state_q == S_BURST);
  assign issue_last = issue & (rem_q == '0);

  // -------------------------------------------------------------------------
  // Burst sequencing
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    id_d    = id_q;
`ifndef COB_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifndef COB_ARB_FIXED_PRIO_EN
          rr_d = ~acc_id;
`endif
          // A zero-length request is consumed without starting a burst.
          if (acc_len != '0) begin
            state_d = S_BURST;
            cur_d   = acc_base;
            rem_d   = acc_len - LEN_W'(1);
            id_d    = acc_id;
          end
        end
      end
      S_BURST: begin
        // Address wraps naturally at the top of the ROM.
        cur_d = cur_q + ADDR_W'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Tag pipeline: shift in one entry per cycle, valid only on read cycles.
  // The extended vectors keep the shift expression legal for ROM_LAT == 1.
  // -------------------------------------------------------------------------
  assign pv_ext = {pv_q, issue};
  assign pi_ext = {pi_q, id_q};
  assign pl_ext = {pl_q, issue_last};

  always_comb begin
    pv_d = pv_ext[ROM_LAT-1:0];
    pi_d = pi_ext[ROM_LAT-1:0];
    pl_d = pl_ext[ROM_LAT-1:0];
  end

  // -------------------------------------------------------------------------
  // State registers. Reset flushes the tag pipeline so ROM data still in
  // flight is never presented as valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      pv_q    <= '0;
      pi_q    <= '0;
      pl_q    <= '0;
`ifndef COB_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
      pl_q    <= pl_d;
`ifndef COB_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all decoded directly from flops except the data pass-through)
  // -------------------------------------------------------------------------
  assign rom_ena   = issue;
  assign rom_addr  = cur_q;
  assign para_val  = pv_q[ROM_LAT-1];
  assign para_id   = pi_q[ROM_LAT-1];
  assign para_last = pl_q[ROM_LAT-1];
  assign para_out  = rom_dout;
  assign busy      = issue | (|pv_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cob_rom_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cob_rom_fetch_arbiter
//
// Drives two DUT copies (ROM_LAT = 1 and ROM_LAT = 2) with identical request
// stimulus. A transaction-level reference model (queue of pending reads,
// history of issued reads) predicts every cycle's outputs. Directed table
// vectors and hand-written sequences cover the burst, wrap, zero-length,
// arbitration and mid-burst reset cases; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_cob_rom_fetch_arbiter;

  // clock / reset ------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // stimulus -----------------------------------------------------------------
  logic        req0_val, req1_val;
  logic [9:0]  req0_base, req1_base;
  logic [10:0] req0_len, req1_len;

  // DUT 1 (ROM_LAT = 1)
  logic        rdy0_a, rdy1_a, ena_a, pv_a, pid_a, pl_a, busy_a, st_a;
  logic [9:0]  addr_a;
  logic [15:0] dout_a, pout_a;
  // DUT 2 (ROM_LAT = 2)
  logic        rdy0_b, rdy1_b, ena_b, pv_b, pid_b, pl_b, busy_b, st_b;
  logic [9:0]  addr_b;
  logic [15:0] dout_b, pout_b, r2a;

  cob_rom_fetch_arbiter #(.ADDR_W(10), .DATA_W(16), .LEN_W(11), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_val(req0_val), .req0_rdy(rdy0_a), .req0_base(req0_base), .req0_len(req0_len),
    .req1_val(req1_val), .req1_rdy(rdy1_a), .req1_base(req1_base), .req1_len(req1_len),
    .rom_ena(ena_a), .rom_addr(addr_a), .rom_dout(dout_a),
    .para_val(pv_a), .para_out(pout_a), .para_id(pid_a), .para_last(pl_a),
    .busy(busy_a), .dbg_state(st_a)
  );

  cob_rom_fetch_arbiter #(.ADDR_W(10), .DATA_W(16), .LEN_W(11), .ROM_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_val(req0_val), .req0_rdy(rdy0_b), .req0_base(req0_base), .req0_len(req0_len),
    .req1_val(req1_val), .req1_rdy(rdy1_b), .req1_base(req1_base), .req1_len(req1_len),
    .rom_ena(ena_b), .rom_addr(addr_b), .rom_dout(dout_b),
    .para_val(pv_b), .para_out(pout_b), .para_id(pid_b), .para_last(pl_b),
    .busy(busy_b), .dbg_state(st_b)
  );

  // ROM contents: an injective function of the address.
  function automatic logic [15:0] rom_f(input logic [9:0] a);
    return {a[3:0], 2'b10, a} ^ 16'h3C5A;
  endfunction

  always_ff @(posedge clk) begin
    if (ena_a) dout_a <= rom_f(addr_a);
  end
  always_ff @(posedge clk) begin
    if (ena_b) r2a <= rom_f(addr_b);
    dout_b <= r2a;
  end

  // scoreboard counters --------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model -----------------------------------------------------------
  typedef struct packed { logic [9:0] addr; logic id; logic last; } rd_t;
  typedef struct packed { logic val; logic id; logic last; logic [9:0] addr; } hs_t;

  rd_t  rq[$];         // reads still to be issued, in order
  hs_t  hist [2];      // hist[0]: read issued last cycle, hist[1]: two cycles ago
  logic m_rr = 1'b0;   // requester favoured on a tie
  bit   armed = 1'b0;

  // observed values of the current cycle, for the directed sequences
  logic obs_rdy0, obs_rdy1, obs_ena1, obs_pv1, obs_pl1, obs_pid1, obs_busy1, obs_st1;
  logic obs_ena2, obs_pv2;
  logic [9:0] obs_addr1;

  task automatic chk_dut(input string tag, input logic ena, input logic [9:0] addr,
                         input logic pv, input logic pid, input logic pl,
                         input logic [15:0] pout, input logic bsy,
                         input logic r0, input logic r1, input hs_t h,
                         input logic e_ena, input logic [9:0] e_addr,
                         input logic e_busy, input logic e0, input logic e1);
    chk({tag, "_rom_ena"}, ena, e_ena);
    if (e_ena) chk({tag, "_rom_addr"}, addr, e_addr);
    chk({tag, "_para_val"}, pv, h.val);
    if (h.val) begin
      chk({tag, "_para_id"}, pid, h.id);
      chk({tag, "_para_last"}, pl, h.last);
      chk({tag, "_para_out"}, pout, rom_f(h.addr));
    end
    chk({tag, "_busy"}, bsy, e_busy);
    chk({tag, "_req0_rdy"}, r0, e0);
    chk({tag, "_req1_rdy"}, r1, e1);
  endtask

  // One clock cycle: check at the falling edge, advance the model, then return
  // 1 time unit after the rising edge where new inputs may be driven.
  task automatic tick();
    logic e_ena, g0, g1, e0, e1, rs;
    rd_t  cur;
    logic [9:0]  a_base;
    logic [10:0] a_len;
    logic        a_id;
    @(negedge clk);
    rs    = rst_n;
    e_ena = (rq.size() != 0);
    cur   = e_ena ? rq[0] : '0;
`ifdef COB_ARB_FIXED_PRIO_EN
    g0 = req0_val;
    g1 = req1_val && !req0_val;
`else
    g0 = req0_val && (!req1_val || m_rr == 1'b0);
    g1 = req1_val && (!req0_val || m_rr == 1'b1);
`endif
    e0 = rs && !e_ena && g0;
    e1 = rs && !e_ena && g1;

    obs_rdy0 = rdy0_a;  obs_rdy1 = rdy1_a;  obs_ena1 = ena_a;  obs_addr1 = addr_a;
    obs_pv1  = pv_a;    obs_pl1  = pl_a;    obs_pid1 = pid_a;  obs_busy1 = busy_a;
    obs_st1  = st_a;    obs_ena2 = ena_b;   obs_pv2  = pv_b;

    if (armed) begin
      chk_dut("d1", ena_a, addr_a, pv_a, pid_a, pl_a, pout_a, busy_a, rdy0_a, rdy1_a,
              hist[0], e_ena, cur.addr, e_ena | hist[0].val, e0, e1);
      chk_dut("d2", ena_b, addr_b, pv_b, pid_b, pl_b, pout_b, busy_b, rdy0_b, rdy1_b,
              hist[1], e_ena, cur.addr, e_ena | hist[0].val | hist[1].val, e0, e1);
    end

    if (!rs) begin
      rq.delete();
      hist[0] = '0;
      hist[1] = '0;
      m_rr    = 1'b0;
    end else begin
      hist[1] = hist[0];
      hist[0] = e_ena ? {1'b1, cur.id, cur.last, cur.addr} : '0;
      if (e_ena) void'(rq.pop_front());
      if (e0 || e1) begin
        a_id   = e1;
        a_base = e1 ? req1_base : req0_base;
        a_len  = e1 ? req1_len  : req0_len;
        m_rr   = ~a_id;
        for (int k = 0; k < int'(a_len); k++) begin
          logic [9:0] a;
          a = a_base + 10'(k);
          rq.push_back({a, a_id, (k == int'(a_len) - 1)});
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rs) armed = 1'b1;
  endtask

  // driver tasks -------------------------------------------------------------
  task automatic do_reset();
    rst_n = 1'b0;
    req0_val = 1'b0;
    req1_val = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic id, input logic [9:0] base, input logic [10:0] len);
    if (id) begin
      req1_val = 1'b1; req1_base = base; req1_len = len;
    end else begin
      req0_val = 1'b1; req0_base = base; req0_len = len;
    end
  endtask

  // directed table -----------------------------------------------------------
  typedef struct {
    logic        id;
    logic [9:0]  base;
    logic [10:0] len;
    int          exp_reads;
    logic [9:0]  exp_last;
  } vec_t;
  vec_t vt [6];

  initial begin : main
    int acc_cyc, nreads, npv, lastbeat, last_rd_cyc, busy_low_cyc;
    logic [9:0] lastaddr;
    logic lastid, acc, any_st;
    int gcount;
    logic [3:0] gid, exp_gid;
    logic stale;

    vt[0] = '{1'b0, 10'd5,    11'd4, 4, 10'd8};
    vt[1] = '{1'b1, 10'd1022, 11'd3, 3, 10'd0};
    vt[2] = '{1'b0, 10'd40,   11'd0, 0, 10'd0};
    vt[3] = '{1'b1, 10'd1023, 11'd1, 1, 10'd1023};
    vt[4] = '{1'b0, 10'd1020, 11'd8, 8, 10'd3};
    vt[5] = '{1'b1, 10'd0,    11'd0, 0, 10'd0};

    req0_val = 1'b0; req1_val = 1'b0;
    req0_base = '0; req1_base = '0; req0_len = '0; req1_len = '0;
    rst_n = 1'b0;

    // Reset state
    do_reset();
    tick();
    chk("rst_rom_ena", obs_ena1, 1'b0);
    chk("rst_para_val", obs_pv1, 1'b0);
    chk("rst_busy", obs_busy1, 1'b0);
    chk("rst_rom_addr", obs_addr1, 10'd0);
    chk("rst_rdy0_idle", obs_rdy0, 1'b0);
    drive_req(1'b0, 10'd7, 11'd0);
    tick();
    chk("rst_rdy0_on_val", obs_rdy0, 1'b1);
    chk("rst_rdy1_on_val0", obs_rdy1, 1'b0);
    req0_val = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      drive_req(vt[i].id, vt[i].base, vt[i].len);
      acc = 1'b0;
      acc_cyc = -1;
      for (int c = 0; c < 10 && !acc; c++) begin
        tick();
        if (vt[i].id ? obs_rdy1 : obs_rdy0) begin
          acc = 1'b1;
          acc_cyc = c;
        end
      end
      chk("tbl_accept_cycle", acc_cyc, 0);
      req0_val = 1'b0;
      req1_val = 1'b0;
      nreads = 0; npv = 0; lastbeat = 0; lastaddr = '0; lastid = 1'b0;
      last_rd_cyc = -1; busy_low_cyc = -1; any_st = 1'b0;
      for (int c = 0; c < int'(vt[i].len) + 6; c++) begin
        tick();
        any_st = any_st | obs_st1;
        if (obs_ena1) begin
          nreads++;
          lastaddr = obs_addr1;
          last_rd_cyc = c;
        end
        if (obs_pv1) begin
          npv++;
          if (obs_pl1) begin
            lastbeat = npv;
            lastid = obs_pid1;
          end
        end
        if (!obs_busy1 && busy_low_cyc < 0 && nreads == vt[i].exp_reads) busy_low_cyc = c;
      end
      chk("tbl_reads", nreads, vt[i].exp_reads);
      chk("tbl_para_beats", npv, vt[i].exp_reads);
      if (vt[i].exp_reads > 0) begin
        chk("tbl_last_addr", lastaddr, vt[i].exp_last);
        chk("tbl_last_beat", lastbeat, vt[i].exp_reads);
        chk("tbl_last_id", lastid, vt[i].id);
        chk("tbl_busy_drop", busy_low_cyc - last_rd_cyc, 2);
      end else begin
        chk("tbl_len0_fsm_idle", any_st, 1'b0);
      end
    end

    // Both requesters held valid: grant order
    do_reset();
    req0_base = 10'd100; req0_len = 11'd2;
    req1_base = 10'd200; req1_len = 11'd2;
    req0_val = 1'b1; req1_val = 1'b1;
    gcount = 0;
    gid = '0;
    for (int c = 0; c < 40 && gcount < 4; c++) begin
      tick();
      if (obs_rdy0 || obs_rdy1) begin
        gid[gcount] = obs_rdy1;
        gcount++;
      end
    end
    req0_val = 1'b0; req1_val = 1'b0;
`ifdef COB_ARB_FIXED_PRIO_EN
    exp_gid = 4'b0000;
`else
    exp_gid = 4'b1010;
`endif
    chk("arb_grant_count", gcount, 4);
    chk("arb_grant_order", gid, exp_gid);
    for (int c = 0; c < 10; c++) tick();

    // Reset on the 3rd read of a len=8 burst
    do_reset();
    drive_req(1'b0, 10'd300, 11'd8);
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      tick();
      acc = obs_rdy0;
    end
    chk("mrst_accept", acc, 1'b1);
    req0_val = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_third_read", obs_ena2, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("mrst_rom_ena", obs_ena2, 1'b0);
    chk("mrst_para_val", obs_pv2, 1'b0);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      stale = stale | obs_pv2 | obs_pv1 | obs_ena2;
    end
    chk("mrst_no_stale", stale, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      req0_val  = 1'($urandom_range(0, 1));
      req1_val  = 1'($urandom_range(0, 1));
      req0_base = 10'($urandom_range(0, 1023));
      req1_base = 10'($urandom_range(0, 1023));
      req0_len  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom_range(0, 5));
      req1_len  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom_range(0, 5));
      tick();
    end
    rst_n = 1'b1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    chk("end_idle_busy", obs_busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
